// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the store lane helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, WB} lsu_state_t;

  function automatic logic load_f3_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic store_f3_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

  // Halfwords only look at off[1], so a misaligned halfword lands on its aligned lane.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load lane extraction: selects the byte/halfword/word at the
// given offset and sign- or zero-extends it according to funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];
    result   = word;
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: IDLE -> ACCESS (mem req/ack) -> WB for loads.
// Build option MISALIGN_TRAP_EN turns misaligned halfword/word accesses into faults.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [4:0]        rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_en,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              busy,
  output logic              fault
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  lsu_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             capture, fault_d, leave_access, req_bad, misalign;
  logic             ld_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [4:0]       rd_q;
  logic [31:0]      rdata_q;

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_bad = (is_load == is_store) ||
                   (is_load  && !load_f3_ok(funct3)) ||
                   (is_store && !store_f3_ok(funct3)) ||
                   misalign;

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    capture      = 1'b0;
    fault_d      = 1'b0;
    leave_access = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            fault_d = 1'b1;
          end else begin
            capture = 1'b1;
            cnt_d   = '0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          leave_access = 1'b1;
          state_d      = ld_q ? WB : IDLE;
        end else if (cnt == CNT_LAST) begin
          leave_access = 1'b1;
          fault_d      = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      fault     <= 1'b0;
      ld_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      rd_q      <= '0;
      rdata_q   <= '0;
    end else begin
      fault <= fault_d;
      if (capture) begin
        mem_req   <= 1'b1;
        mem_we    <= is_store;
        mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
        mem_wdata <= store_wdata(funct3, store_data);
        mem_be    <= is_store ? store_be(funct3, addr[1:0]) : 4'b0000;
        ld_q      <= is_load;
        f3_q      <= funct3;
        off_q     <= addr[1:0];
        rd_q      <= rd;
      end
      if (leave_access) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        mem_be  <= 4'b0000;
      end
      if ((state == ACCESS) && mem_ack && ld_q) rdata_q <= mem_rdata;
    end
  end

  load_extend u_load_extend (
    .word   (rdata_q),
    .off    (off_q),
    .funct3 (f3_q),
    .result (wb_data)
  );

  // x0 is never written, but WB is still visited to keep load latency fixed.
  assign wb_en     = (state == WB) && (rd_q != 5'd0);
  assign wb_rd     = rd_q;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random accesses
// compared against an arithmetic reference model of the access rules.
module tb_load_store_unit;

  localparam int ACK_TIMEOUT = 16;
  localparam int ADDR_W      = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, is_load, is_store;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr, mem_addr;
  logic [31:0]       store_data, mem_wdata, mem_rdata, wb_data;
  logic [4:0]        rd, wb_rd;
  logic              mem_req, mem_we, mem_ack, wb_en, busy, fault;
  logic [3:0]        mem_be;

  int checks   = 0;
  int failures = 0;
  int wb_count = 0;

  load_store_unit #(.ACK_TIMEOUT(ACK_TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
    .store_data(store_data), .rd(rd), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wb_en === 1'b1) wb_count++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Number of bytes moved by an access of this width code.
  function automatic int access_bytes(input logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  // Byte offset actually used: halfwords round down to an even lane, words use lane 0.
  function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
    int n = access_bytes(f3);
    return ((a % 4) / n) * n;
  endfunction

  function automatic bit model_valid(input bit ld, input bit st, input logic [2:0] f3,
                                     input logic [31:0] a);
    if (ld == st) return 1'b0;
    if (ld && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b0;
    if (st && f3 > 2) return 1'b0;
`ifdef MISALIGN_TRAP_EN
    if ((a % access_bytes(f3)) != 0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [2:0] f3);
    int     n    = access_bytes(f3);
    longint val  = (longint'(word) >> (8 * lane_off(f3, a))) & ((64'd1 << (8 * n)) - 1);
    longint half = 64'd1 << (8 * n - 1);
    if (f3 < 4 && n < 4 && val >= half) val = val - 2 * half;
    return val[31:0];
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int be = ((1 << access_bytes(f3)) - 1) << lane_off(f3, a);
    return be[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int     n   = access_bytes(f3);
    longint low = longint'(sd) & ((64'd1 << (8 * n)) - 1);
    longint w   = 0;
    for (int i = 0; i < 4 / n; i++) w = w | (low << (8 * n * i));
    return w[31:0];
  endfunction

  // One complete access: present the request, model memory with 'delay' idle
  // cycles before ack (>= ACK_TIMEOUT means never ack), then check the outcome.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r,
                        input int delay, input logic [31:0] rword);
    bit ok;
    int wb0;
    ok  = model_valid(ld, st, f3, a);
    wb0 = wb_count;
    check("pre_ready", req_ready, 1);
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
    addr = a; store_data = sd; rd = r;
    step();
    req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    if (!ok) begin
      check("bad_fault", fault, 1);
      check("bad_mem_req", mem_req, 0);
      check("bad_ready", req_ready, 1);
      step();
      check("bad_fault_clear", fault, 0);
      check("bad_no_wb", wb_count, wb0);
      return;
    end
    check("acc_busy", busy, 1);
    check("acc_ready", req_ready, 0);
    check("acc_addr", mem_addr, a & 32'hFFFF_FFFC);
    check("acc_we", mem_we, st);
    check("acc_be", mem_be, st ? model_be(f3, a) : 4'b0000);
    if (st) check("acc_wdata", mem_wdata, model_wdata(f3, sd));
    for (int i = 0; i < delay && i < ACK_TIMEOUT; i++) begin
      check("acc_req_held", mem_req, 1);
      check("acc_no_fault", fault, 0);
      step();
    end
    if (delay >= ACK_TIMEOUT) begin
      check("to_fault", fault, 1);
      check("to_mem_req", mem_req, 0);
      check("to_ready", req_ready, 1);
      step();
      check("to_fault_clear", fault, 0);
      check("to_no_wb", wb_count, wb0);
      return;
    end
    check("acc_req", mem_req, 1);
    check("acc_addr_stable", mem_addr, a & 32'hFFFF_FFFC);
    mem_ack = 1'b1; mem_rdata = rword;
    step();
    mem_ack = 1'b0; mem_rdata = $urandom;
    check("done_mem_req", mem_req, 0);
    check("done_fault", fault, 0);
    if (st) begin
      check("st_ready", req_ready, 1);
      step();
      check("st_no_wb", wb_count, wb0);
    end else begin
      check("ld_wb_ready", req_ready, 0);
      check("ld_wb_en", wb_en, (r != 0));
      check("ld_wb_rd", wb_rd, r);
      check("ld_wb_data", wb_data, model_load(rword, a, f3));
      step();
      check("ld_ready", req_ready, 1);
      check("ld_wb_en_clear", wb_en, 0);
      check("ld_wb_count", wb_count, wb0 + ((r != 0) ? 1 : 0));
    end
  endtask

  initial begin
    int wb_snap;
    rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = '0;
    addr = '0; store_data = '0; rd = '0; mem_ack = 1'b0; mem_rdata = '0;
    step();
    step();
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_fault", fault, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_data", wb_data, 0);
    rst = 1'b0;
    step();

    // Directed cases
    run_op(1, 0, 3'b000, 32'h103, 32'h0, 5'd7,  0, 32'h80FF_1234); // LB sign-extend
    run_op(1, 0, 3'b101, 32'h102, 32'h0, 5'd9,  0, 32'hBEEF_0000); // LHU upper half
    run_op(0, 1, 3'b000, 32'h201, 32'hA5, 5'd3, 0, 32'h0);         // SB lane 1
    run_op(0, 1, 3'b001, 32'h202, 32'h1234_5678, 5'd0, 2, 32'h0);  // SH upper half
    run_op(0, 1, 3'b010, 32'h300, 32'hDEAD_BEEF, 5'd0, 1, 32'h0);  // SW
    run_op(1, 0, 3'b010, 32'h400, 32'h0, 5'd4, ACK_TIMEOUT, 32'h0); // LW timeout
    run_op(1, 0, 3'b010, 32'h404, 32'h0, 5'd5, ACK_TIMEOUT - 1, 32'hCAFE_F00D); // last-chance ack
    run_op(1, 0, 3'b001, 32'h101, 32'h0, 5'd6, 0, 32'h1234_8765);  // LH misaligned
    run_op(1, 0, 3'b010, 32'h503, 32'h0, 5'd8, 0, 32'h0BAD_F00D);  // LW misaligned
    run_op(1, 1, 3'b000, 32'h100, 32'h0, 5'd1, 0, 32'h0);          // load and store both set
    run_op(0, 0, 3'b000, 32'h100, 32'h0, 5'd1, 0, 32'h0);          // neither set
    run_op(1, 0, 3'b011, 32'h100, 32'h0, 5'd1, 0, 32'h0);          // bad load funct3
    run_op(0, 1, 3'b100, 32'h100, 32'h0, 5'd1, 0, 32'h0);          // bad store funct3

    // mem_ack while idle must not start anything
    wb_snap = wb_count;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    check("idle_ack_busy", busy, 0);
    check("idle_ack_fault", fault, 0);
    step();
    check("idle_ack_no_wb", wb_count, wb_snap);

    // LW to x0, then reset in the middle of the next load
    wb_snap = wb_count;
    run_op(1, 0, 3'b010, 32'h600, 32'h0, 5'd0, 0, 32'h1111_2222);
    check("x0_no_wb", wb_count, wb_snap);
    req_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h700; rd = 5'd12;
    step();
    req_valid = 1'b0; is_load = 1'b0;
    check("mid_req", mem_req, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_mem_req", mem_req, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_be", mem_be, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_wdata", mem_wdata, 0);
    check("mid_rst_wb_rd", wb_rd, 0);
    check("mid_rst_wb_data", wb_data, 0);
    check("mid_rst_fault", fault, 0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    check("mid_rst_no_fault", fault, 0);
    check("mid_rst_no_wb", wb_count, wb_snap);

    // Randomized accesses
    for (int n = 0; n < 80; n++) begin
      int  sel, dly;
      bit  ld, st;
      sel = $urandom_range(0, 9);
      ld  = (sel == 1) || (sel >= 2 && sel <= 5);
      st  = (sel == 1) || (sel >= 6);
      dly = ($urandom_range(0, 14) == 0) ? ACK_TIMEOUT : $urandom_range(0, 3);
      run_op(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom,
             5'($urandom_range(0, 31)), dly, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
